// File: rtl/median_frame_sequencer.sv
// median_frame_sequencer: frame controller around the 3x3 row median core.
// Streams NROWS source rows into the core and writes each result row back.
module median_frame_sequencer #(
  parameter int NROWS   = 256,
  parameter int ADDR_W  = 8,
  parameter int OUT_LAT = 2,
  parameter int GAP     = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_overrun,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              core_set_n,
  output logic              core_rst_n,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int CW = ADDR_W + 1;
  localparam int FW = $clog2(NROWS + OUT_LAT + 2) + 1;
  localparam int GW = $clog2(GAP + 1) + 1;

  localparam logic [CW-1:0] C_LAST = CW'(NROWS - 1);
  localparam logic [CW-1:0] C_END  = CW'(NROWS);
  localparam logic [FW-1:0] F_WR   = FW'(OUT_LAT + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_FINISH,
    S_GAPW
  } state_t;

  state_t r_state;

  logic              r_pending;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_set_n;
  logic              r_rst_n;
  logic              r_wr_en;
  logic [CW-1:0]     r_rd_cnt;
  logic [CW-1:0]     r_wr_cnt;
  logic [FW-1:0]     r_fcnt;
  logic [GW-1:0]     r_gap_cnt;

  logic          w_req;
  logic          w_run;
  logic          w_gap_last;
  logic          w_wr_last;
  logic          w_prime;
  logic [FW-1:0] w_fnext;

  assign w_req      = start | r_pending;
  assign w_run      = r_state inside {S_PRIME, S_STREAM, S_DRAIN};
  assign w_gap_last = (r_state == S_GAPW) && (r_gap_cnt == G_LAST);
  assign w_wr_last  = r_wr_en && (r_wr_cnt == C_LAST);
  assign w_fnext    = r_fcnt + FW'(1);
  assign w_prime    = w_req && ((r_state == S_IDLE) || w_gap_last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_set_n   <= 1'b1;
      r_rst_n   <= 1'b1;
      r_wr_en   <= 1'b0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_fcnt    <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_done  <= 1'b0;
      r_set_n <= 1'b1;
      r_rst_n <= 1'b1;

      // A start landing on the last gap cycle survives as the next request.
      if (r_state == S_IDLE) begin
        r_pending <= 1'b0;
      end else if (w_gap_last) begin
        r_pending <= r_pending & start;
      end else if (start) begin
        if (r_pending) r_err <= 1'b1;
        else           r_pending <= 1'b1;
      end

      // Write window is timed from PRIME, not from the read state.
      if (w_run) begin
        r_fcnt <= w_fnext;
        if (w_wr_last) begin
          r_wr_en  <= 1'b0;
          r_wr_cnt <= '0;
        end else if (r_wr_en) begin
          r_wr_cnt <= r_wr_cnt + CW'(1);
        end else if (w_fnext == F_WR) begin
          r_wr_en <= 1'b1;
        end
      end

      unique case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_PRIME, S_STREAM: begin
          if (r_rd_cnt == C_END) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_cnt[ADDR_W-1:0];
            r_rd_cnt  <= r_rd_cnt + CW'(1);
            r_state   <= S_STREAM;
          end
        end
        S_DRAIN: begin
          if (w_wr_last) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_busy    <= 1'b0;
          r_gap_cnt <= '0;
          r_state   <= S_GAPW;
        end
        S_GAPW: begin
          if (w_gap_last) r_state <= S_IDLE;
          else            r_gap_cnt <= r_gap_cnt + GW'(1);
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_prime) begin
        r_state   <= S_PRIME;
        r_busy    <= 1'b1;
        r_rd_en   <= 1'b1;
        r_rd_addr <= '0;
        r_rd_cnt  <= CW'(1);
        r_set_n   <= 1'b0;
        r_rst_n   <= 1'b0;
        r_fcnt    <= '0;
        r_wr_en   <= 1'b0;
        r_wr_cnt  <= '0;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err_overrun = r_err;
  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;
  assign core_set_n  = r_set_n;
  assign core_rst_n  = r_rst_n;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_cnt[ADDR_W-1:0];

endmodule

// File: tb/tb_median_frame_sequencer.sv
// tb_median_frame_sequencer: directed tables, corner sequences and a
// randomized run against a frame-offset reference model.
module tb_median_frame_sequencer;

  logic CLK;
  logic RST;

  logic       b_start, b_busy, b_done, b_err, b_rd_en;
  logic       b_set_n, b_rst_n, b_wr_en;
  logic [7:0] b_rd_addr, b_wr_addr;

  logic       m_start, m_busy, m_done, m_err, m_rd_en;
  logic       m_set_n, m_rst_n, m_wr_en;
  logic [1:0] m_rd_addr, m_wr_addr;

  logic       q_start, q_busy, q_done, q_err, q_rd_en;
  logic       q_set_n, q_rst_n, q_wr_en;
  logic [2:0] q_rd_addr, q_wr_addr;

  median_frame_sequencer u_big (
    .CLK(CLK), .RST(RST), .start(b_start),
    .busy(b_busy), .done(b_done), .err_overrun(b_err),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .core_set_n(b_set_n), .core_rst_n(b_rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr)
  );

  median_frame_sequencer #(
    .NROWS(3), .ADDR_W(2), .OUT_LAT(0), .GAP(1)
  ) u_min (
    .CLK(CLK), .RST(RST), .start(m_start),
    .busy(m_busy), .done(m_done), .err_overrun(m_err),
    .rd_en(m_rd_en), .rd_addr(m_rd_addr),
    .core_set_n(m_set_n), .core_rst_n(m_rst_n),
    .wr_en(m_wr_en), .wr_addr(m_wr_addr)
  );

  localparam int RN   = 6;
  localparam int RL   = 3;
  localparam int RG   = 3;
  localparam int RLEN = 1 + RL + RN;

  median_frame_sequencer #(
    .NROWS(RN), .ADDR_W(3), .OUT_LAT(RL), .GAP(RG)
  ) u_rnd (
    .CLK(CLK), .RST(RST), .start(q_start),
    .busy(q_busy), .done(q_done), .err_overrun(q_err),
    .rd_en(q_rd_en), .rd_addr(q_rd_addr),
    .core_set_n(q_set_n), .core_rst_n(q_rst_n),
    .wr_en(q_wr_en), .wr_addr(q_wr_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int tt = 0;

  typedef struct {
    int cyc;
    bit st;
    int busy;
    int done;
    int rd_en;
    int rd_addr;
    int wr_en;
    int wr_addr;
    int set_n;
    int err;
  } vec_t;

  vec_t vec[19];

  task automatic chk(input string nm, input int tc, input int act, input int exp);
    if (exp >= 0) begin
      n_cmp++;
      if (act != exp) begin
        n_bad++;
        $display("FAIL %s @t=%0d: got %0d, expected %0d", nm, tc, act, exp);
      end
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
    tt++;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    b_start = 1'b0;
    m_start = 1'b0;
    q_start = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tt = 0;
  endtask

  task automatic chk_big_idle(input string nm);
    chk({nm, "_busy"}, tt, int'(b_busy), 0);
    chk({nm, "_done"}, tt, int'(b_done), 0);
    chk({nm, "_err"}, tt, int'(b_err), 0);
    chk({nm, "_rd_en"}, tt, int'(b_rd_en), 0);
    chk({nm, "_rd_addr"}, tt, int'(b_rd_addr), 0);
    chk({nm, "_wr_en"}, tt, int'(b_wr_en), 0);
    chk({nm, "_wr_addr"}, tt, int'(b_wr_addr), 0);
    chk({nm, "_set_n"}, tt, int'(b_set_n), 1);
    chk({nm, "_rst_n"}, tt, int'(b_rst_n), 1);
  endtask

  // Reference model: frame outputs are pure functions of the offset
  // from the PRIME cycle; requests follow the pending/overrun rules.
  int mp;
  bit mpend;
  bit merr;
  int qt;

  task automatic model_check();
    int k;
    bit act;
    int e_rd;
    int e_wr;
    k = qt - mp;
    act = (mp >= 0) && (k <= RLEN + RG);
    e_rd = (act && k < RN) ? 1 : 0;
    e_wr = (act && k >= 1 + RL && k <= RL + RN) ? 1 : 0;
    chk("rnd_busy", qt, int'(q_busy), (act && k <= RLEN) ? 1 : 0);
    chk("rnd_done", qt, int'(q_done), (act && k == RLEN) ? 1 : 0);
    chk("rnd_rd_en", qt, int'(q_rd_en), e_rd);
    chk("rnd_rd_addr", qt, int'(q_rd_addr), e_rd ? k : -1);
    chk("rnd_wr_en", qt, int'(q_wr_en), e_wr);
    chk("rnd_wr_addr", qt, int'(q_wr_addr), e_wr ? k - 1 - RL : 0);
    chk("rnd_set_n", qt, int'(q_set_n), (act && k == 0) ? 0 : 1);
    chk("rnd_rst_n", qt, int'(q_rst_n), (act && k == 0) ? 0 : 1);
    chk("rnd_err", qt, int'(q_err), int'(merr));
  endtask

  task automatic model_edge(input bit s);
    int k;
    bit act;
    k = qt - mp;
    act = (mp >= 0) && (k <= RLEN + RG);
    if (!act) begin
      if (s || mpend) begin
        mp = qt + 1;
        mpend = 1'b0;
      end
    end else if (k == RLEN + RG) begin
      if (s || mpend) mp = qt + 1;
      mpend = mpend && s;
    end else if (s) begin
      if (mpend) merr = 1'b1;
      else       mpend = 1'b1;
    end
  endtask

  initial begin
    int idx;
    int nd;
    int np;
    int nb;
    int p;
    bit s;
    int e_rd_en[6];
    int e_rd_addr[6];
    int e_wr_en[6];
    int e_wr_addr[6];
    int e_done[6];
    int e_set[6];
    int e_busy[6];

    vec[0]  = '{0,   1'b1, 0, 0, 0, 0,   0, 0,   1, 0};
    vec[1]  = '{1,   1'b0, 1, 0, 1, 0,   0, 0,   0, 0};
    vec[2]  = '{2,   1'b0, 1, 0, 1, 1,   0, 0,   1, 0};
    vec[3]  = '{3,   1'b0, 1, 0, 1, 2,   0, 0,   1, 0};
    vec[4]  = '{4,   1'b0, 1, 0, 1, 3,   1, 0,   1, 0};
    vec[5]  = '{5,   1'b0, 1, 0, 1, 4,   1, 1,   1, 0};
    vec[6]  = '{100, 1'b1, 1, 0, 1, 99,  1, 96,  1, 0};
    vec[7]  = '{101, 1'b0, 1, 0, 1, 100, 1, 97,  1, 0};
    vec[8]  = '{256, 1'b0, 1, 0, 1, 255, 1, 252, 1, 0};
    vec[9]  = '{257, 1'b0, 1, 0, 0, -1,  1, 253, 1, 0};
    vec[10] = '{259, 1'b0, 1, 0, 0, -1,  1, 255, 1, 0};
    vec[11] = '{260, 1'b0, 1, 1, 0, -1,  0, 0,   1, 0};
    vec[12] = '{261, 1'b0, 0, 0, 0, -1,  0, 0,   1, 0};
    vec[13] = '{262, 1'b0, 1, 0, 1, 0,   0, 0,   0, 0};
    vec[14] = '{263, 1'b0, 1, 0, 1, 1,   0, 0,   1, 0};
    vec[15] = '{521, 1'b0, 1, 1, 0, -1,  0, 0,   1, 0};
    vec[16] = '{522, 1'b0, 0, 0, 0, -1,  0, 0,   1, 0};
    vec[17] = '{523, 1'b0, 0, 0, 0, -1,  0, 0,   1, 0};
    vec[18] = '{530, 1'b0, 0, 0, 0, -1,  0, 0,   1, 0};

    e_rd_en   = '{1, 1, 1, 0, 0, 0};
    e_rd_addr = '{0, 1, 2, -1, -1, -1};
    e_wr_en   = '{0, 1, 1, 1, 0, 0};
    e_wr_addr = '{0, 0, 1, 2, 0, 0};
    e_done    = '{0, 0, 0, 0, 1, 0};
    e_set     = '{0, 1, 1, 1, 1, 1};
    e_busy    = '{1, 1, 1, 1, 1, 0};

    RST = 1'b1;
    b_start = 1'b0;
    m_start = 1'b0;
    q_start = 1'b0;
    #1 RST = 1'b0;
    #2;
    chk_big_idle("reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tt = 0;

    // Single frame plus one queued request, default geometry.
    for (int c = 0; c <= 530; c++) begin
      idx = -1;
      for (int i = 0; i < 19; i++)
        if (vec[i].cyc == c) idx = i;
      b_start = (idx >= 0) ? vec[idx].st : 1'b0;
      @(negedge CLK);
      if (idx >= 0) begin
        chk("tab_busy", c, int'(b_busy), vec[idx].busy);
        chk("tab_done", c, int'(b_done), vec[idx].done);
        chk("tab_rd_en", c, int'(b_rd_en), vec[idx].rd_en);
        chk("tab_rd_addr", c, int'(b_rd_addr), vec[idx].rd_addr);
        chk("tab_wr_en", c, int'(b_wr_en), vec[idx].wr_en);
        chk("tab_wr_addr", c, int'(b_wr_addr), vec[idx].wr_addr);
        chk("tab_set_n", c, int'(b_set_n), vec[idx].set_n);
        chk("tab_rst_n", c, int'(b_rst_n), vec[idx].set_n);
        chk("tab_err", c, int'(b_err), vec[idx].err);
      end
      @(posedge CLK);
      #1;
    end

    // Two extra requests during one frame: overrun, single extra frame.
    do_reset();
    b_start = 1'b1;
    adv();
    b_start = 1'b0;
    while (tt < 100) adv();
    b_start = 1'b1;
    adv();
    b_start = 1'b0;
    chk("ovr_err_101", tt, int'(b_err), 0);
    while (tt < 150) adv();
    chk("ovr_err_150", tt, int'(b_err), 0);
    b_start = 1'b1;
    adv();
    b_start = 1'b0;
    chk("ovr_err_151", tt, int'(b_err), 1);
    while (tt < 261) adv();
    chk("ovr_busy_261", tt, int'(b_busy), 0);
    adv();
    chk("ovr_prime_262", tt, int'(b_set_n), 0);
    nd = 0;
    np = 0;
    while (tt < 560) begin
      adv();
      if (b_done) nd++;
      if (!b_set_n) np++;
      if (tt == 521) chk("ovr_done_521", tt, int'(b_done), 1);
    end
    chk("ovr_done_cnt", tt, nd, 1);
    chk("ovr_third_prime", tt, np, 0);
    chk("ovr_err_sticky", tt, int'(b_err), 1);

    // Reset asserted mid-STREAM aborts the frame at once.
    do_reset();
    b_start = 1'b1;
    adv();
    b_start = 1'b0;
    while (tt < 130) adv();
    chk("rst_pre_addr", tt, int'(b_rd_addr), 129);
    #2;
    RST = 1'b0;
    #1;
    chk_big_idle("rst_async");
    nd = 0;
    nb = 0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (b_done) nd++;
      if (b_busy) nb++;
    end
    RST = 1'b1;
    tt = 0;
    adv();
    adv();
    if (b_done) nd++;
    if (b_busy) nb++;
    b_start = 1'b1;
    adv();
    b_start = 1'b0;
    p = tt;
    chk("rst_re_busy", tt, int'(b_busy), 1);
    chk("rst_re_rd_en", tt, int'(b_rd_en), 1);
    chk("rst_re_rd_addr", tt, int'(b_rd_addr), 0);
    chk("rst_re_set_n", tt, int'(b_set_n), 0);
    chk("rst_re_rst_n", tt, int'(b_rst_n), 0);
    chk("rst_re_wr_en", tt, int'(b_wr_en), 0);
    while (tt < p + 259) begin
      if (b_done) nd++;
      adv();
    end
    chk("rst_no_done", tt, nd, 0);
    chk("rst_no_busy", tt, nb, 0);
    chk("rst_re_done", tt, int'(b_done), 1);

    // Minimum frame, no core latency.
    do_reset();
    m_start = 1'b1;
    adv();
    m_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("min_rd_en", tt, int'(m_rd_en), e_rd_en[i]);
      chk("min_rd_addr", tt, int'(m_rd_addr), e_rd_addr[i]);
      chk("min_wr_en", tt, int'(m_wr_en), e_wr_en[i]);
      chk("min_wr_addr", tt, int'(m_wr_addr), e_wr_addr[i]);
      chk("min_done", tt, int'(m_done), e_done[i]);
      chk("min_set_n", tt, int'(m_set_n), e_set[i]);
      chk("min_rst_n", tt, int'(m_rst_n), e_set[i]);
      chk("min_busy", tt, int'(m_busy), e_busy[i]);
      adv();
    end

    // start held for four cycles: two frames, overrun flagged.
    do_reset();
    nd = 0;
    np = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) chk("held_err_2", tt, int'(m_err), 0);
      if (i == 3) chk("held_err_3", tt, int'(m_err), 1);
      if (!m_set_n) np++;
      if (m_done) nd++;
      m_start = 1'b1;
      adv();
    end
    m_start = 1'b0;
    repeat (30) begin
      if (!m_set_n) np++;
      if (m_done) nd++;
      adv();
    end
    chk("held_frames", tt, np, 2);
    chk("held_dones", tt, nd, 2);
    chk("held_err", tt, int'(m_err), 1);

    // Randomized requests and resets against the reference model.
    do_reset();
    mp = -1;
    mpend = 1'b0;
    merr = 1'b0;
    qt = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        RST = 1'b0;
        q_start = 1'b0;
        #1;
        mp = -1;
        mpend = 1'b0;
        merr = 1'b0;
        model_check();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        qt++;
      end
      s = ($urandom_range(0, 7) == 0);
      q_start = s;
      @(negedge CLK);
      model_check();
      @(posedge CLK);
      model_edge(s);
      qt++;
      #1;
    end
    q_start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
